// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared encodings for the UART transmit path: FSM states and output-mux select codes.
// The mux decode helpers keep the select mapping in one place for the controller and the mux bench.
package uart_tx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    function automatic logic [1:0] sel_of(input state_t s);
        logic [1:0] sel;
        case (s)
            ST_START:  sel = SEL_START;
            ST_DATA:   sel = SEL_DATA;
            ST_PARITY: sel = SEL_PAR;
            default:   sel = SEL_STOP;
        endcase
        return sel;
    endfunction

    function automatic logic busy_of(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_serializer.sv
// Payload shift register and bit counter: loads on acceptance, shifts LSB-first
// while enabled, flags the last payload bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load_i,
    input  logic                  clear_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ser_data_o,
    output logic                  done_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    // Next-state for the shift register and the bit counter; counter holds at LAST.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
        end else begin
            shreg_d = shreg_q;
        end
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Payload and counter registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_data_o = shreg_q[0];
    assign done_o     = shift_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: frame FSM, parity generation and the registered
// select/busy outputs feeding the downstream 4:1 line mux.
module uart_tx_frame_ctrl
    import uart_tx_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  SER_DATA,
    output logic                  PAR_BIT,
    output logic [1:0]            MUX_SEL,
    output logic                  BUSY
);

    state_t     state_q, state_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;
    logic [1:0] mux_sel_q, mux_sel_d;
    logic       busy_q, busy_d;
    logic       accept_s;
    logic       done_s;

    // A new frame may only be taken when idle or in the final stop bit.
    assign accept_s = DATA_VALID && ((state_q == ST_IDLE) || (state_q == ST_STOP));

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (accept_s),
        .clear_i    (state_q == ST_START),
        .shift_i    (state_q == ST_DATA),
        .data_i     (P_DATA),
        .ser_data_o (SER_DATA),
        .done_o     (done_s)
    );

    // Next-state logic; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = accept_s ? ST_START : ST_IDLE;
            ST_START:  state_d = ST_DATA;
            ST_DATA: begin
                if (done_s) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = accept_s ? ST_START : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        mux_sel_d = sel_of(state_d);
        busy_d    = busy_of(state_d);
        if (accept_s) begin
            par_en_d  = PAR_EN;
            par_bit_d = (^P_DATA) ^ PAR_TYP;
        end else begin
            par_en_d  = par_en_q;
            par_bit_d = par_bit_q;
        end
    end

    // State, latched options and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            mux_sel_q <= SEL_STOP;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            mux_sel_q <= mux_sel_d;
            busy_q    <= busy_d;
        end
    end

    assign PAR_BIT = par_bit_q;
    assign MUX_SEL = mux_sel_q;
    assign BUSY    = busy_q;

endmodule
